// File: rtl/timekeeper_core.sv
// timekeeper_core: calendar clock with a per-second prescaler, set/adjust
// paths and NUM_ALARMS hour:minute alarm channels.
// Optional build macro TIMEKEEPER_LEAP_EN adds Gregorian leap-year Februaries;
// without it February always has 28 days and no leap logic is built.
module timekeeper_core #(
    parameter int CLK_HZ     = 100000000,
    parameter int NUM_ALARMS = 4,
    localparam int AW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_valid,
    input  logic [13:0]           set_year,
    input  logic [3:0]            set_month,
    input  logic [4:0]            set_day,
    input  logic [4:0]            set_hour,
    input  logic [5:0]            set_minute,
    input  logic [5:0]            set_second,
    input  logic                  adj_inc,
    input  logic                  adj_dec,
    input  logic [2:0]            adj_field,
    input  logic                  alarm_wr,
    input  logic [AW-1:0]         alarm_idx,
    input  logic [4:0]            alarm_hour,
    input  logic [5:0]            alarm_minute,
    input  logic                  alarm_on,
    input  logic                  alarm_ack,
    output logic [13:0]           year,
    output logic [3:0]            month,
    output logic [4:0]            day,
    output logic [4:0]            hour,
    output logic [5:0]            minute,
    output logic [5:0]            second,
    output logic                  sec_pulse,
    output logic                  set_err,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  alarm_irq
);

    localparam int            PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    // Days in a month; an illegal month yields 0 so any day check fails.
    function automatic logic [4:0] f_dim(input logic [3:0] mon, input logic leap);
        logic [4:0] d;
        case (mon)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: d = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    d = 5'd30;
            4'd2:                                       d = leap ? 5'd29 : 5'd28;
            default:                                    d = 5'd0;
        endcase
        return d;
    endfunction

    // Time-of-day and control state
    logic [13:0]           r_year;
    logic [3:0]            r_month;
    logic [4:0]            r_day;
    logic [4:0]            r_hour;
    logic [5:0]            r_minute;
    logic [5:0]            r_second;
    logic [PW-1:0]         r_presc;
    logic                  r_hold;
    logic                  r_sec_pulse;
    logic                  r_set_err;
    logic [NUM_ALARMS-1:0] r_pend;
    logic                  r_irq;
    logic [4:0]            r_al_hour [NUM_ALARMS];
    logic [5:0]            r_al_min  [NUM_ALARMS];
    logic                  r_al_on   [NUM_ALARMS];

    logic                  w_leap_cur;
    logic                  w_leap_set;
    logic                  w_leap_adj;

    // Stepped year/month values shared by the carry chain and the adjust path
    logic [13:0] w_year_up, w_year_dn, w_adj_year;
    logic [3:0]  w_mon_up, w_mon_dn, w_adj_month;
    logic [4:0]  w_dim_cur, w_dim_set, w_dim_mon, w_dim_yr;
    logic        w_tick, w_adj_act, w_set_ok;

    assign w_year_up   = (r_year == 14'd9999) ? 14'd0 : (r_year + 14'd1);
    assign w_year_dn   = (r_year == 14'd0) ? 14'd9999 : (r_year - 14'd1);
    assign w_adj_year  = adj_inc ? w_year_up : w_year_dn;
    assign w_mon_up    = (r_month == 4'd12) ? 4'd1 : (r_month + 4'd1);
    assign w_mon_dn    = (r_month <= 4'd1) ? 4'd12 : (r_month - 4'd1);
    assign w_adj_month = adj_inc ? w_mon_up : w_mon_dn;

`ifdef TIMEKEEPER_LEAP_EN
    // Gregorian rule: every 4th year, except centuries not divisible by 400.
    function automatic logic f_is_leap(input logic [13:0] y);
        return (y[1:0] == 2'b00) &&
               (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
    endfunction

    assign w_leap_cur = f_is_leap(r_year);
    assign w_leap_set = f_is_leap(set_year);
    assign w_leap_adj = f_is_leap(w_adj_year);
`else
    assign w_leap_cur = 1'b0;
    assign w_leap_set = 1'b0;
    assign w_leap_adj = 1'b0;
`endif

    assign w_dim_cur = f_dim(r_month, w_leap_cur);
    assign w_dim_set = f_dim(set_month, w_leap_set);
    assign w_dim_mon = f_dim(w_adj_month, w_leap_cur);
    assign w_dim_yr  = f_dim(r_month, w_leap_adj);

    assign w_tick    = (r_presc == PRESC_MAX);
    // Exactly one direction and a real field; otherwise the adjust is a no-op
    // and does not block the tick.
    assign w_adj_act = (adj_inc ^ adj_dec) && (adj_field <= 3'd5);
    assign w_set_ok  = (set_month >= 4'd1) && (set_month <= 4'd12) &&
                       (set_day >= 5'd1) && (set_day <= w_dim_set) &&
                       (set_hour <= 5'd23) && (set_minute <= 6'd59) &&
                       (set_second <= 6'd59);

    logic [13:0] w_adv_year;
    logic [3:0]  w_adv_month;
    logic [4:0]  w_adv_day, w_adv_hour;
    logic [5:0]  w_adv_min, w_adv_sec;

    // One-second advance with the full carry cascade up to the year wrap.
    always_comb begin
        w_adv_year  = r_year;
        w_adv_month = r_month;
        w_adv_day   = r_day;
        w_adv_hour  = r_hour;
        w_adv_min   = r_minute;
        w_adv_sec   = r_second;
        if (r_second == 6'd59) begin
            w_adv_sec = 6'd0;
            if (r_minute == 6'd59) begin
                w_adv_min = 6'd0;
                if (r_hour == 5'd23) begin
                    w_adv_hour = 5'd0;
                    if (r_day >= w_dim_cur) begin
                        w_adv_day = 5'd1;
                        if (r_month == 4'd12) begin
                            w_adv_month = 4'd1;
                            w_adv_year  = w_year_up;
                        end else begin
                            w_adv_month = r_month + 4'd1;
                        end
                    end else begin
                        w_adv_day = r_day + 5'd1;
                    end
                end else begin
                    w_adv_hour = r_hour + 5'd1;
                end
            end else begin
                w_adv_min = r_minute + 6'd1;
            end
        end else begin
            w_adv_sec = r_second + 6'd1;
        end
    end

    logic [13:0]   w_nxt_year;
    logic [3:0]    w_nxt_month;
    logic [4:0]    w_nxt_day, w_nxt_hour;
    logic [5:0]    w_nxt_min, w_nxt_sec;
    logic [PW-1:0] w_nxt_presc;
    logic          w_nxt_hold, w_nxt_pulse, w_nxt_err, w_adv_en;

    // Next state with priority set > adjust > tick; a tick blocked by an
    // adjust (or a rejected set) is held and applied on a later free cycle.
    always_comb begin
        w_nxt_year  = r_year;
        w_nxt_month = r_month;
        w_nxt_day   = r_day;
        w_nxt_hour  = r_hour;
        w_nxt_min   = r_minute;
        w_nxt_sec   = r_second;
        w_nxt_presc = w_tick ? {PW{1'b0}} : (r_presc + PW'(1));
        w_nxt_hold  = 1'b0;
        w_nxt_pulse = 1'b0;
        w_nxt_err   = 1'b0;
        w_adv_en    = 1'b0;
        if (set_valid) begin
            if (w_set_ok) begin
                w_nxt_year  = set_year;
                w_nxt_month = set_month;
                w_nxt_day   = set_day;
                w_nxt_hour  = set_hour;
                w_nxt_min   = set_minute;
                w_nxt_sec   = set_second;
                w_nxt_presc = {PW{1'b0}};
            end else begin
                w_nxt_err  = 1'b1;
                w_nxt_hold = w_tick | r_hold;
            end
        end else if (w_adj_act) begin
            w_nxt_hold = w_tick | r_hold;
            case (adj_field)
                3'd0: w_nxt_sec  = adj_inc ? ((r_second == 6'd59) ? 6'd0 : (r_second + 6'd1))
                                           : ((r_second == 6'd0) ? 6'd59 : (r_second - 6'd1));
                3'd1: w_nxt_min  = adj_inc ? ((r_minute == 6'd59) ? 6'd0 : (r_minute + 6'd1))
                                           : ((r_minute == 6'd0) ? 6'd59 : (r_minute - 6'd1));
                3'd2: w_nxt_hour = adj_inc ? ((r_hour == 5'd23) ? 5'd0 : (r_hour + 5'd1))
                                           : ((r_hour == 5'd0) ? 5'd23 : (r_hour - 5'd1));
                3'd3: w_nxt_day  = adj_inc ? ((r_day >= w_dim_cur) ? 5'd1 : (r_day + 5'd1))
                                           : ((r_day <= 5'd1) ? w_dim_cur : (r_day - 5'd1));
                3'd4: begin
                    w_nxt_month = w_adj_month;
                    w_nxt_day   = (r_day > w_dim_mon) ? w_dim_mon : r_day;
                end
                3'd5: begin
                    w_nxt_year = w_adj_year;
                    w_nxt_day  = (r_day > w_dim_yr) ? w_dim_yr : r_day;
                end
                default: w_nxt_sec = r_second;
            endcase
        end else if (w_tick | r_hold) begin
            w_nxt_year  = w_adv_year;
            w_nxt_month = w_adv_month;
            w_nxt_day   = w_adv_day;
            w_nxt_hour  = w_adv_hour;
            w_nxt_min   = w_adv_min;
            w_nxt_sec   = w_adv_sec;
            w_nxt_pulse = 1'b1;
            w_adv_en    = 1'b1;
        end else begin
            w_nxt_hold = 1'b0;
        end
    end

    logic [NUM_ALARMS-1:0] w_hit;

    // Alarm match only when a tick lands on the top of a minute.
    always_comb begin
        w_hit = {NUM_ALARMS{1'b0}};
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (w_adv_en && (w_adv_sec == 6'd0) && r_al_on[i] &&
                (r_al_hour[i] == w_adv_hour) && (r_al_min[i] == w_adv_min)) begin
                w_hit[i] = 1'b1;
            end else begin
                w_hit[i] = 1'b0;
            end
        end
    end

    // Time, prescaler, pulses and alarm status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_year      <= 14'd2024;
            r_month     <= 4'd1;
            r_day       <= 5'd1;
            r_hour      <= 5'd0;
            r_minute    <= 6'd0;
            r_second    <= 6'd0;
            r_presc     <= {PW{1'b0}};
            r_hold      <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_set_err   <= 1'b0;
            r_pend      <= {NUM_ALARMS{1'b0}};
            r_irq       <= 1'b0;
        end else begin
            r_year      <= w_nxt_year;
            r_month     <= w_nxt_month;
            r_day       <= w_nxt_day;
            r_hour      <= w_nxt_hour;
            r_minute    <= w_nxt_min;
            r_second    <= w_nxt_sec;
            r_presc     <= w_nxt_presc;
            r_hold      <= w_nxt_hold;
            r_sec_pulse <= w_nxt_pulse;
            r_set_err   <= w_nxt_err;
            // A new match wins over a coincident acknowledge.
            r_pend      <= (alarm_ack ? {NUM_ALARMS{1'b0}} : r_pend) | w_hit;
            r_irq       <= |r_pend;
        end
    end

    // Alarm table; an index with no matching channel writes nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_al_hour[i] <= 5'd0;
                r_al_min[i]  <= 6'd0;
                r_al_on[i]   <= 1'b0;
            end
        end else if (alarm_wr) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_idx == AW'(i)) begin
                    r_al_hour[i] <= alarm_hour;
                    r_al_min[i]  <= alarm_minute;
                    r_al_on[i]   <= alarm_on;
                end
            end
        end
    end

    assign year          = r_year;
    assign month         = r_month;
    assign day           = r_day;
    assign hour          = r_hour;
    assign minute        = r_minute;
    assign second        = r_second;
    assign sec_pulse     = r_sec_pulse;
    assign set_err       = r_set_err;
    assign alarm_pending = r_pend;
    assign alarm_irq     = r_irq;

endmodule
